vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Generates VGA raster timing: horizontal/vertical counters, sync pulses and blanking, and drives the pixel coordinates (`vga_x`, `vga_y`) consumed by the combinational pixel-colour generators.
It accepts the colour those generators return for the current coordinate and registers it together with the delayed syncs, so the DAC sees colour and sync aligned.
It sits between the colour generators and the board VGA DAC/connector pins.

## Interface
Parameters:
- `H_ACTIVE` default 640: visible pixels per line
- `H_FP` default 16: horizontal front porch, in pixels
- `H_SYNC` default 96: hsync width, in pixels
- `H_BP` default 48: horizontal back porch, in pixels
- `V_ACTIVE` default 480: visible lines
- `V_FP` default 10: vertical front porch, in lines
- `V_SYNC` default 2: vsync width, in lines
- `V_BP` default 33: vertical back porch, in lines
- `SYNC_POL` default 0: sync asserted level; 0 means active-low sync

Ports:
- `clk` in, 1 bit: system clock.
- `rst_n` in, 1 bit: asynchronous, active-low reset.
- `pix_en` in, 1 bit: pixel-rate enable. The raster advances only on `clk` edges where `pix_en` is 1.
- `vga_x` out, 11 bits: current horizontal count, `h_cnt`.
- `vga_y` out, 11 bits: current vertical count, `v_cnt`.
- `video_on` out, 1 bit: combinational; 1 when `h_cnt < H_ACTIVE` and `v_cnt < V_ACTIVE`.
- `box_r`, `box_g`, `box_b` in, 8 bits each: colour for the current (`vga_x`, `vga_y`), returned combinationally in the same cycle.
- `vga_r`, `vga_g`, `vga_b` out, 8 bits each: registered colour to the DAC.
- `vga_hs` out, 1 bit: registered horizontal sync.
- `vga_vs` out, 1 bit: registered vertical sync.
- `vga_blank_n` out, 1 bit: registered; 1 during active video.
- `frame_start` out, 1 bit: single-`clk` pulse marking the start of a frame.

## Operation
- Totals: `H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP`; `V_TOTAL` is defined the same way from the vertical parameters. Both must be ≤ 2048 (11-bit counters).
- Horizontal count on a `pix_en` cycle: if `h_cnt == H_TOTAL-1`, `h_cnt` goes to 0; otherwise it increments.
- Vertical count: changes only on the `pix_en` cycle where `h_cnt` wraps.
  - If `v_cnt == V_TOTAL-1`, `v_cnt` goes to 0; otherwise it increments.
- `vga_x`/`vga_y` carry the raw counter values over the full range 0..`H_TOTAL-1` and 0..`V_TOTAL-1`, including blanking. Colour generators qualify with `video_on`.
- Horizontal sync window: `h_cnt` in [`H_ACTIVE+H_FP`, `H_ACTIVE+H_FP+H_SYNC`). The vertical window on `v_cnt` is defined the same way.
  - Inside the window, sync equals `SYNC_POL`; outside, it equals `~SYNC_POL`.
- Output register, updated on `pix_en` cycles only:
  - `vga_hs`, `vga_vs` and `vga_blank_n` take the values decoded from the pre-advance counters.
  - `vga_r/g/b` take `box_*` when `video_on`, else 0.
- `frame_start` is 1 for exactly one `clk` cycle: the cycle after the `pix_en` edge on which both counters wrap to (0,0). It is 0 at all other times.
- While `pix_en` is 0, all counters and registered outputs hold, and `frame_start` is 0.
- Reset values, applied asynchronously on `rst_n` low:
  - `h_cnt = v_cnt = 0`.
  - `vga_hs = vga_vs = ~SYNC_POL`.
  - `vga_blank_n = 0`, `vga_r/g/b = 0`, `frame_start = 0`.
- Reset mid-frame: the raster restarts at (0,0) on the first `pix_en` after `rst_n` releases. No sync glitch is produced; syncs stay deasserted during reset. No `frame_start` pulse is produced for the reset itself.

## Timing
- Coordinate to pixel-output latency: 1 `pix_en` period. The colour for coordinate (x, y) appears on `vga_r/g/b` together with the sync and blank values decoded for (x, y).
- Combinational path `vga_x/y` → colour generator → `box_*` → output register must close within one `clk` period.
- Frame period: `H_TOTAL*V_TOTAL` `pix_en` cycles, which is 800*525 = 420000 with the defaults.
- `pix_en` may be tied to 1 (`clk` is the pixel clock) or be a 1-in-N strobe. Behaviour does not depend on the spacing of `pix_en` pulses.

## Structure
- Shared package `vga_pkg`:
  - 640x480@60 timing constants (the defaults above).
  - Coordinate width constant (11).
  - Colour width constant (8).
  - Sync-polarity constants.
- One natural sub-module, `vga_axis_counter`: a parameterised wrap counter with `en` and `wrap` outputs, instantiated once for horizontal and once for vertical. The vertical instance is enabled by `pix_en & h_wrap`.
- Sync/blank decode and the output register stay in the top level.

## Test plan
- Reset then `pix_en=1`, defaults:
  - `vga_hs` falls when (x=656 registered) and stays low for 96 cycles.
  - `vga_vs` is low for exactly 2 lines, starting at line 490.
  - Line period is 800 cycles; frame period is 420000 cycles.
- `box_*` driven with `{x[7:0], y[7:0], 8'hA5}`: at every active pixel, `vga_r/g/b` equals the value for the previous cycle's (x, y). It is 0 whenever `vga_blank_n` = 0 (e.g. x=640..799).
- `pix_en` strobed every 2nd `clk`: all outputs change only on strobe edges. The line period is 1600 `clk` cycles.
- Wrap at (799, 524) → (0, 0): `frame_start` pulses for exactly 1 `clk`, once per frame. A `pix_en=0` gap inserted at the wrap produces no extra pulse.
- `rst_n` asserted at (x=300, y=200) for 5 cycles:
  - During reset, outputs are immediately at their reset values with syncs high.
  - After release, `vga_x` = 0 and `vga_y` = 0 on the first `pix_en`, with no `frame_start` pulse.
- `SYNC_POL=1`: sync pulses are high inside the windows, and the reset level is 0.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA raster constants, pixel types and decode helpers.
// Defaults describe the 640x480@60 raster on an 11-bit coordinate grid.
package vga_pkg;

  localparam int CW    = 11;
  localparam int COL_W = 8;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam bit SYNC_ACTIVE_LOW  = 1'b0;
  localparam bit SYNC_ACTIVE_HIGH = 1'b1;

  typedef logic [CW-1:0]    coord_t;
  typedef logic [COL_W-1:0] col_t;

  typedef struct packed {
    col_t r;
    col_t g;
    col_t b;
  } rgb_t;

  // True when c lies in [lo, lo+len).
  function automatic logic in_win(
    input coord_t c,
    input int     lo,
    input int     len
  );
    return (int'(c) >= lo) && (int'(c) < lo + len);
  endfunction

  // Sync pin level for a window hit under the given polarity.
  function automatic logic sync_lvl(
    input logic hit,
    input logic pol
  );
    return hit ? pol : ~pol;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: 0..TOTAL-1 wrap counter for one raster axis.
// Ports: clk, rst_n, en (advance), cnt (count), wrap (at TOTAL-1).
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int TOTAL = 800
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en,
  output coord_t cnt,
  output logic   wrap
);

  localparam coord_t LAST = coord_t'(TOTAL - 1);

  // Terminal count; the caller gates it with en to form a real wrap.
  assign wrap = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster counters, sync/blank decode, colour output reg.
// Ports: clk, rst_n, pix_en in; vga_x/y, video_on to colour generators;
// box_r/g/b back in; vga_r/g/b, vga_hs/vs, vga_blank_n, frame_start out.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter bit SYNC_POL = SYNC_ACTIVE_LOW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pix_en,
  output logic [CW-1:0] vga_x,
  output logic [CW-1:0] vga_y,
  output logic          video_on,
  input  logic [7:0]    box_r,
  input  logic [7:0]    box_g,
  input  logic [7:0]    box_b,
  output logic [7:0]    vga_r,
  output logic [7:0]    vga_g,
  output logic [7:0]    vga_b,
  output logic          vga_hs,
  output logic          vga_vs,
  output logic          vga_blank_n,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  coord_t h_cnt;
  coord_t v_cnt;
  logic   h_wrap;
  logic   v_wrap;
  logic   v_en;
  logic   hs_d;
  logic   vs_d;
  rgb_t   pix_q;

  vga_axis_counter #(
    .TOTAL(H_TOTAL)
  ) u_h (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (pix_en),
    .cnt  (h_cnt),
    .wrap (h_wrap)
  );

  assign v_en = pix_en & h_wrap;

  vga_axis_counter #(
    .TOTAL(V_TOTAL)
  ) u_v (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (v_en),
    .cnt  (v_cnt),
    .wrap (v_wrap)
  );

  assign vga_x = h_cnt;
  assign vga_y = v_cnt;

  assign video_on = in_win(h_cnt, 0, H_ACTIVE)
                 && in_win(v_cnt, 0, V_ACTIVE);

  assign hs_d = sync_lvl(
    in_win(h_cnt, H_ACTIVE + H_FP, H_SYNC), SYNC_POL);
  assign vs_d = sync_lvl(
    in_win(v_cnt, V_ACTIVE + V_FP, V_SYNC), SYNC_POL);

  // Decode uses the pre-advance count, so colour, sync and blank
  // leave this register together, one pixel behind vga_x/vga_y.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_hs      <= ~SYNC_POL;
      vga_vs      <= ~SYNC_POL;
      vga_blank_n <= 1'b0;
      pix_q       <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= v_en & v_wrap;
      if (pix_en) begin
        vga_hs      <= hs_d;
        vga_vs      <= vs_d;
        vga_blank_n <= video_on;
        if (video_on) begin
          pix_q <= '{r: box_r, g: box_g, b: box_b};
        end else begin
          pix_q <= '0;
        end
      end
    end
  end

  assign vga_r = pix_q.r;
  assign vga_g = pix_q.g;
  assign vga_b = pix_q.b;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench on a shrunken 15x8 raster,
// with a second instance at SYNC_POL=1 sharing the same stimulus.
module tb_vga_timing_gen;

  localparam int HA = 8;
  localparam int HF = 2;
  localparam int HS = 3;
  localparam int HB = 2;
  localparam int VA = 4;
  localparam int VF = 1;
  localparam int VS = 2;
  localparam int VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pix_en = 1'b0;
  logic [10:0] vga_x, vga_y;
  logic        video_on;
  logic [7:0]  box_r, box_g, box_b;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, vga_blank_n, frame_start;

  logic [10:0] p_x, p_y;
  logic        p_on;
  logic [7:0]  p_r, p_g, p_b;
  logic        p_hs, p_vs, p_bn, p_fs;

  always #5 clk = ~clk;

  assign box_r = vga_x[7:0];
  assign box_g = vga_y[7:0];
  assign box_b = 8'hA5;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
    .vga_x(vga_x), .vga_y(vga_y), .video_on(video_on),
    .box_r(box_r), .box_g(box_g), .box_b(box_b),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_blank_n(vga_blank_n), .frame_start(frame_start)
  );

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b1)
  ) u_dut_p (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
    .vga_x(p_x), .vga_y(p_y), .video_on(p_on),
    .box_r(box_r), .box_g(box_g), .box_b(box_b),
    .vga_r(p_r), .vga_g(p_g), .vga_b(p_b),
    .vga_hs(p_hs), .vga_vs(p_vs),
    .vga_blank_n(p_bn), .frame_start(p_fs)
  );

  typedef struct {
    int          ph;
    logic [51:0] v;
  } sb_t;

  sb_t q[$];

  int tests = 0;
  int fails = 0;
  int fs_exp = 0;
  int fs_seen = 0;

  logic [10:0] mx = '0;
  logic [10:0] my = '0;
  logic        e_hs = 1'b1, e_vs = 1'b1, e_bn = 1'b0, e_fs = 1'b0;
  logic        e_hs1 = 1'b0, e_vs1 = 1'b0;
  logic [23:0] e_rgb = '0;
  int          phase = 0;

  function automatic logic [51:0] act_vec();
    return {vga_x, vga_y, vga_hs, vga_vs, vga_blank_n,
            vga_r, vga_g, vga_b, frame_start, p_hs, p_vs};
  endfunction

  // One clk cycle: drive inputs at negedge, push the expected
  // post-edge outputs from the bench raster model.
  task automatic step(input logic pe, input logic rs);
    logic act, was_rst;
    @(negedge clk);
    was_rst = rst_n;
    pix_en = pe;
    rst_n = rs;
    if (!rs) begin
      mx = '0; my = '0;
      e_hs = 1'b1; e_vs = 1'b1; e_hs1 = 1'b0; e_vs1 = 1'b0;
      e_bn = 1'b0; e_rgb = '0; e_fs = 1'b0;
      if (was_rst) begin
        #1;
        tests++;
        if (act_vec() !== {11'd0, 11'd0, 1'b1, 1'b1, 1'b0,
                           24'd0, 1'b0, 1'b0, 1'b0}) begin
          fails++;
          $display("FAIL async_reset: got %h want reset values",
                   act_vec());
        end
      end
    end else begin
      e_fs = 1'b0;
      if (pe) begin
        act = (mx < HA) && (my < VA);
        e_hs1 = (mx >= HA + HF) && (mx < HA + HF + HS);
        e_vs1 = (my >= VA + VF) && (my < VA + VF + VS);
        e_hs = ~e_hs1;
        e_vs = ~e_vs1;
        e_bn = act;
        e_rgb = act ? {mx[7:0], my[7:0], 8'hA5} : 24'd0;
        e_fs = (mx == HT - 1) && (my == VT - 1);
        if (e_fs) fs_exp++;
        if (mx == HT - 1) begin
          mx = '0;
          my = (my == VT - 1) ? '0 : my + 1'b1;
        end else begin
          mx = mx + 1'b1;
        end
      end
    end
    q.push_back('{ph: phase,
                  v: {mx, my, e_hs, e_vs, e_bn, e_rgb,
                      e_fs, e_hs1, e_vs1}});
  endtask

  // Monitor: every clk edge presents a new output state.
  logic fs_prev = 1'b0;
  initial begin
    sb_t e;
    forever begin
      @(posedge clk);
      #1;
      if (frame_start) begin
        fs_seen++;
        tests++;
        if (fs_prev) begin
          fails++;
          $display("FAIL fs_width: frame_start high 2 cycles, want 1");
        end
      end
      fs_prev = frame_start;
      if (q.size() > 0) begin
        e = q.pop_front();
        tests++;
        if (act_vec() !== e.v) begin
          fails++;
          $display("FAIL sb_phase%0d: got %h want %h",
                   e.ph, act_vec(), e.v);
        end
      end
    end
  end

  initial begin
    // reset with pix_en high
    phase = 0;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    // two full frames at pix_en = 1
    phase = 1;
    for (int i = 0; i < 2 * HT * VT; i++) step(1'b1, 1'b1);
    // 1-in-2 strobe for one frame
    phase = 2;
    for (int i = 0; i < 2 * HT * VT; i++) step(1'(i % 2), 1'b1);
    // pix_en gap right at the frame wrap
    phase = 3;
    for (int i = 0; i < 3 * HT * VT; i++) begin
      if (mx == HT - 1 && my == VT - 1) break;
      step(1'b1, 1'b1);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1);
    // irregular strobe
    phase = 4;
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 2) == 0), 1'b1);
    // reset mid-frame at (5,2)
    phase = 5;
    for (int i = 0; i < 3 * HT * VT; i++) begin
      if (mx == 5 && my == 2) break;
      step(1'b1, 1'b1);
    end
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 2 * HT * VT; i++) step(1'b1, 1'b1);
    @(posedge clk);
    #3;
    tests++;
    if (fs_seen != fs_exp) begin
      fails++;
      $display("FAIL fs_count: got %0d pulses want %0d",
               fs_seen, fs_exp);
    end
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL sb_drain: %0d entries left want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
